// File: rtl/amem_port_ctl.sv
// A-memory port sequencer: one A-source read per microcycle step, followed by
// commit of any pending write-back, with pass-around of uncommitted write data.
module amem_port_ctl #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  step,
   input  logic [ADDR_WIDTH-1:0] a_src,
   input  logic                  wb_valid,
   input  logic [ADDR_WIDTH-1:0] wb_adr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  wb_ready,
   input  logic [DATA_WIDTH-1:0] amem,
   output logic [ADDR_WIDTH-1:0] aadr,
   output logic                  arp,
   output logic                  awp,
   output logic [DATA_WIDTH-1:0] l,
   output logic [DATA_WIDTH-1:0] a_bus,
   output logic                  a_valid,
   output logic                  pass,
   output logic                  busy
);

   localparam int unsigned CNT_W = 2;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] WRITE = 2'd3;

   logic [1:0]            state,     state_nxt;
   logic [CNT_W-1:0]      cnt,       cnt_nxt;
   logic [ADDR_WIDTH-1:0] rd_adr,    rd_adr_nxt;
   logic [ADDR_WIDTH-1:0] pend_adr,  pend_adr_nxt;
   logic [DATA_WIDTH-1:0] pend_data, pend_data_nxt;
   logic                  pending,   pending_nxt;
   logic [DATA_WIDTH-1:0] a_bus_nxt;
   logic                  pass_nxt;
   logic                  cap;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] aadr_nxt;
   logic                  arp_nxt;
   logic                  awp_nxt;
   logic [DATA_WIDTH-1:0] l_nxt;
   logic                  busy_nxt;
   logic                  wb_ready_nxt;

   // Next-state, pending-write, capture and (pre-registered) output logic
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      rd_adr_nxt    = rd_adr;
      pend_adr_nxt  = pend_adr;
      pend_data_nxt = pend_data;
      pending_nxt   = pending;
      a_bus_nxt     = a_bus;
      pass_nxt      = pass;
      cap           = 1'b0;

      accept = wb_valid & wb_ready;
      if (accept) begin
         pend_adr_nxt  = wb_adr;
         pend_data_nxt = wb_data;
         pending_nxt   = 1'b1;
      end

      case (state)
         IDLE: begin
            if (step) begin
               rd_adr_nxt = a_src;
               state_nxt  = READ;
            end
         end
         READ: begin
            cnt_nxt   = CNT_W'(RD_LAT - 1);
            state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == '0) begin
               cap = 1'b1;
               // Newest write wins: same-cycle offer, then pending, then memory
               if (accept && (wb_adr == rd_adr)) begin
                  a_bus_nxt = wb_data;
                  pass_nxt  = 1'b1;
               end else if (pending && (pend_adr == rd_adr)) begin
                  a_bus_nxt = pend_data;
                  pass_nxt  = 1'b1;
               end else begin
                  a_bus_nxt = amem;
                  pass_nxt  = 1'b0;
               end
               state_nxt = pending_nxt ? WRITE : IDLE;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         WRITE: begin
            // A write-back accepted while committing replaces the pending entry
            if (!accept) begin
               pending_nxt = 1'b0;
            end
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      aadr_nxt     = ((state_nxt == READ) || (state_nxt == WAIT)) ? rd_adr_nxt : pend_adr_nxt;
      arp_nxt      = (state_nxt == READ);
      awp_nxt      = (state_nxt == WRITE);
      l_nxt        = pend_data_nxt;
      busy_nxt     = (state_nxt != IDLE);
      wb_ready_nxt = !pending_nxt || (state_nxt == WRITE);
   end

   // State, pending write and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         rd_adr    <= '0;
         pend_adr  <= '0;
         pend_data <= '0;
         pending   <= 1'b0;
         a_bus     <= '0;
         pass      <= 1'b0;
         a_valid   <= 1'b0;
         aadr      <= '0;
         arp       <= 1'b0;
         awp       <= 1'b0;
         l         <= '0;
         busy      <= 1'b0;
         wb_ready  <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rd_adr    <= rd_adr_nxt;
         pend_adr  <= pend_adr_nxt;
         pend_data <= pend_data_nxt;
         pending   <= pending_nxt;
         a_bus     <= a_bus_nxt;
         pass      <= pass_nxt;
         a_valid   <= cap;
         aadr      <= aadr_nxt;
         arp       <= arp_nxt;
         awp       <= awp_nxt;
         l         <= l_nxt;
         busy      <= busy_nxt;
         wb_ready  <= wb_ready_nxt;
      end
   end

endmodule

// File: tb/tb_amem_port_ctl.sv
// Bench for amem_port_ctl: two instances (RD_LAT 1 and 3), each with its own
// A memory model; a transaction-level reference predicts every output per cycle.
module tb_amem_port_ctl;

   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          sel = 1'b0;
   logic          step = 1'b0;
   logic [AW-1:0] a_src = '0;
   logic          wb_valid = 1'b0;
   logic [AW-1:0] wb_adr = '0;
   logic [DW-1:0] wb_data = '0;

   logic          step1, step3, wbv1, wbv3;
   logic          wbr1, arp1, awp1, av1, pass1, busy1;
   logic          wbr3, arp3, awp3, av3, pass3, busy3;
   logic [AW-1:0] aadr1, aadr3;
   logic [DW-1:0] l1, l3, abus1, abus3, amem1, amem3;

   logic          o_wbr, o_arp, o_awp, o_av, o_pass, o_busy;
   logic [AW-1:0] o_aadr;
   logic [DW-1:0] o_l, o_abus;

   always #5 clk = ~clk;

   assign step1 = step & ~sel;
   assign step3 = step & sel;
   assign wbv1  = wb_valid & ~sel;
   assign wbv3  = wb_valid & sel;

   assign o_wbr  = sel ? wbr3  : wbr1;
   assign o_arp  = sel ? arp3  : arp1;
   assign o_awp  = sel ? awp3  : awp1;
   assign o_av   = sel ? av3   : av1;
   assign o_pass = sel ? pass3 : pass1;
   assign o_busy = sel ? busy3 : busy1;
   assign o_aadr = sel ? aadr3 : aadr1;
   assign o_l    = sel ? l3    : l1;
   assign o_abus = sel ? abus3 : abus1;

   amem_port_ctl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .step(step1), .a_src(a_src),
      .wb_valid(wbv1), .wb_adr(wb_adr), .wb_data(wb_data), .wb_ready(wbr1),
      .amem(amem1), .aadr(aadr1), .arp(arp1), .awp(awp1), .l(l1),
      .a_bus(abus1), .a_valid(av1), .pass(pass1), .busy(busy1));

   amem_port_ctl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .step(step3), .a_src(a_src),
      .wb_valid(wbv3), .wb_adr(wb_adr), .wb_data(wb_data), .wb_ready(wbr3),
      .amem(amem3), .aadr(aadr3), .arp(arp3), .awp(awp3), .l(l3),
      .a_bus(abus3), .a_valid(av3), .pass(pass3), .busy(busy3));

   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      if (a == 10'h010) return 32'h12345678;
      return 32'hA5A50000 ^ (DW'(a) * 32'h00010003);
   endfunction

   // A memories: registered reads of RD_LAT cycles, unwritten words read init_val
   logic [DW-1:0] mem1 [1024];
   logic [DW-1:0] mem3 [1024];
   bit            wr1  [1024];
   bit            wr3  [1024];
   logic [DW-1:0] p1;
   logic [DW-1:0] p3 [3];

   always @(posedge clk) begin
      if (awp1) begin
         mem1[aadr1] <= l1;
         wr1[aadr1]  <= 1'b1;
      end
      if (arp1) p1 <= wr1[aadr1] ? mem1[aadr1] : init_val(aadr1);
   end
   assign amem1 = p1;

   always @(posedge clk) begin
      if (awp3) begin
         mem3[aadr3] <= l3;
         wr3[aadr3]  <= 1'b1;
      end
      if (arp3) p3[0] <= wr3[aadr3] ? mem3[aadr3] : init_val(aadr3);
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign amem3 = p3[2];

   // Reference model: committed memory contents plus one pending write entry
   logic [DW-1:0] ref_mem [1024];
   logic          m_pend;
   logic [AW-1:0] m_padr;
   logic [DW-1:0] m_pdata;
   logic [DW-1:0] m_abus;
   logic          m_pass;
   logic          exp_av;
   int            rdl = 1;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input bit cap);
      @(posedge clk);
      #1;
      exp_av = cap;
   endtask

   task automatic chk_hold();
      chk("a_valid", DW'(o_av), DW'(exp_av));
      chk("a_bus",   o_abus,    m_abus);
      chk("pass",    DW'(o_pass), DW'(m_pass));
   endtask

   task automatic chk_idle();
      chk("idle_arp",   DW'(o_arp),  32'd0);
      chk("idle_awp",   DW'(o_awp),  32'd0);
      chk("idle_busy",  DW'(o_busy), 32'd0);
      chk("idle_aadr",  DW'(o_aadr), DW'(m_padr));
      chk("idle_ready", DW'(o_wbr),  DW'(!m_pend));
      chk_hold();
   endtask

   task automatic idle_cycle(input bit offer, input logic [AW-1:0] adr, input logic [DW-1:0] data);
      chk_idle();
      step = 1'($urandom_range(0, 1)) & 1'b0;
      wb_valid = offer;
      wb_adr = adr;
      wb_data = data;
      if (offer && !m_pend) begin
         m_pend = 1'b1;
         m_padr = adr;
         m_pdata = data;
      end
      tick(1'b0);
      wb_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step = 1'b0;
      wb_valid = 1'b0;
      tick(1'b0);
      reset = 1'b0;
      m_pend = 1'b0;
      m_padr = '0;
      m_pdata = '0;
      m_abus = '0;
      m_pass = 1'b0;
      exp_av = 1'b0;
      chk("rst_aadr",  DW'(o_aadr), 32'd0);
      chk("rst_arp",   DW'(o_arp),  32'd0);
      chk("rst_awp",   DW'(o_awp),  32'd0);
      chk("rst_l",     o_l,         32'd0);
      chk("rst_abus",  o_abus,      32'd0);
      chk("rst_avalid", DW'(o_av),  32'd0);
      chk("rst_pass",  DW'(o_pass), 32'd0);
      chk("rst_busy",  DW'(o_busy), 32'd0);
      chk("rst_ready", DW'(o_wbr),  32'd1);
   endtask

   task automatic busy_noise();
      step = 1'($urandom_range(0, 1));
      a_src = AW'($urandom);
   endtask

   task automatic do_step(input logic [AW-1:0] adr,
                          input bit lw_offer, input logic [AW-1:0] lw_adr, input logic [DW-1:0] lw_data,
                          input bit w_offer,  input logic [AW-1:0] w_adr,  input logic [DW-1:0] w_data);
      bit acc;
      chk_idle();
      step = 1'b1;
      a_src = adr;
      wb_valid = 1'b0;
      tick(1'b0);
      // read strobe cycle; offers made while a write is pending must be refused
      chk("read_arp",   DW'(o_arp),  32'd1);
      chk("read_awp",   DW'(o_awp),  32'd0);
      chk("read_aadr",  DW'(o_aadr), DW'(adr));
      chk("read_busy",  DW'(o_busy), 32'd1);
      chk("read_ready", DW'(o_wbr),  DW'(!m_pend));
      chk_hold();
      busy_noise();
      wb_valid = m_pend ? 1'($urandom_range(0, 1)) : 1'b0;
      wb_adr = AW'($urandom);
      wb_data = $urandom;
      tick(1'b0);
      for (int k = 0; k < rdl; k++) begin
         chk("wait_arp",   DW'(o_arp),  32'd0);
         chk("wait_awp",   DW'(o_awp),  32'd0);
         chk("wait_aadr",  DW'(o_aadr), DW'(adr));
         chk("wait_busy",  DW'(o_busy), 32'd1);
         chk("wait_ready", DW'(o_wbr),  DW'(!m_pend));
         chk_hold();
         busy_noise();
         if (k == rdl - 1) begin
            wb_valid = lw_offer;
            wb_adr = lw_adr;
            wb_data = lw_data;
            acc = lw_offer && !m_pend;
            if (acc && lw_adr == adr) begin
               m_abus = lw_data;
               m_pass = 1'b1;
            end else if (m_pend && m_padr == adr) begin
               m_abus = m_pdata;
               m_pass = 1'b1;
            end else begin
               m_abus = ref_mem[adr];
               m_pass = 1'b0;
            end
            if (acc) begin
               m_pend = 1'b1;
               m_padr = lw_adr;
               m_pdata = lw_data;
            end
         end else begin
            wb_valid = m_pend ? 1'($urandom_range(0, 1)) : 1'b0;
            wb_adr = AW'($urandom);
            wb_data = $urandom;
         end
         tick(k == rdl - 1);
      end
      if (m_pend) begin
         chk("write_awp",   DW'(o_awp),  32'd1);
         chk("write_arp",   DW'(o_arp),  32'd0);
         chk("write_aadr",  DW'(o_aadr), DW'(m_padr));
         chk("write_l",     o_l,         m_pdata);
         chk("write_busy",  DW'(o_busy), 32'd1);
         chk("write_ready", DW'(o_wbr),  32'd1);
         chk_hold();
         busy_noise();
         wb_valid = w_offer;
         wb_adr = w_adr;
         wb_data = w_data;
         ref_mem[m_padr] = m_pdata;
         if (w_offer) begin
            m_padr = w_adr;
            m_pdata = w_data;
         end else begin
            m_pend = 1'b0;
         end
         tick(1'b0);
      end
      step = 1'b0;
      wb_valid = 1'b0;
   endtask

   function automatic logic [AW-1:0] pick();
      case ($urandom_range(0, 6))
         0: return 10'h000;
         1: return 10'h3FF;
         2: return 10'h005;
         3: return 10'h010;
         4: return 10'h3FE;
         5: return 10'h001;
         default: return AW'($urandom);
      endcase
   endfunction

   task automatic random_phase(input int n);
      for (int i = 0; i < n; i++) begin
         do_step(pick(), 1'($urandom_range(0, 1)), pick(), $urandom,
                 1'($urandom_range(0, 1)), pick(), $urandom);
         for (int j = 0; j < int'($urandom_range(0, 2)); j++)
            idle_cycle(1'($urandom_range(0, 1)), pick(), $urandom);
      end
   endtask

   task automatic reset_mid_op();
      idle_cycle(1'b1, 10'h077, 32'h0BADF00D);
      chk_idle();
      step = 1'b1;
      a_src = 10'h077;
      tick(1'b0);
      step = 1'b0;
      tick(1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) idle_cycle(1'b0, '0, '0);
      do_step(10'h077, 1'b0, '0, '0, 1'b0, '0, '0);
      chk("rst_discard", m_abus, init_val(10'h077));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(AW'(i));
      m_pend = 1'b0;
      m_padr = '0;
      m_pdata = '0;
      m_abus = '0;
      m_pass = 1'b0;
      exp_av = 1'b0;
      #1;
      do_reset();
      do_reset();

      // quiet after reset
      repeat (3) idle_cycle(1'b0, '0, '0);

      // plain read, no pending write
      do_step(10'h010, 1'b0, '0, '0, 1'b0, '0, '0);
      chk("t2_abus", m_abus, 32'h12345678);
      idle_cycle(1'b0, '0, '0);

      // pending write to the read address passes around, then commits
      idle_cycle(1'b1, 10'h005, 32'hDEADBEEF);
      do_step(10'h005, 1'b0, '0, '0, 1'b0, '0, '0);
      idle_cycle(1'b0, '0, '0);

      // same-cycle write-back in the last wait cycle, top address
      do_step(10'h3FF, 1'b1, 10'h3FF, 32'hCAFEF00D, 1'b0, '0, '0);
      idle_cycle(1'b0, '0, '0);

      // second offer refused while pending, accepted during the commit cycle
      idle_cycle(1'b1, 10'h020, 32'h11111111);
      idle_cycle(1'b1, 10'h021, 32'h22222222);
      do_step(10'h000, 1'b0, '0, '0, 1'b1, 10'h021, 32'h22222222);
      do_step(10'h021, 1'b0, '0, '0, 1'b0, '0, '0);
      do_step(10'h020, 1'b0, '0, '0, 1'b0, '0, '0);
      do_step(10'h3FF, 1'b0, '0, '0, 1'b0, '0, '0);

      random_phase(60);
      reset_mid_op();

      // longer read latency instance
      sel = 1'b1;
      rdl = 3;
      for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(AW'(i));
      do_reset();
      do_step(10'h010, 1'b0, '0, '0, 1'b0, '0, '0);
      idle_cycle(1'b1, 10'h005, 32'hDEADBEEF);
      do_step(10'h005, 1'b0, '0, '0, 1'b0, '0, '0);
      do_step(10'h3FF, 1'b1, 10'h3FF, 32'hCAFEF00D, 1'b0, '0, '0);
      random_phase(40);
      reset_mid_op();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
